// File: rtl/pl_mem_access.sv
// Memory-stage load/store unit: steers stores onto byte lanes, formats loads,
// and stalls the pipeline across a word-aligned req/ack bus transaction.
module pl_mem_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        ErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    fn3_r;
  logic [1:0]    off_r;

  logic          access_s;
  logic          store_s;
  logic          legal_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (f3)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~lo[0];
      2'b10:   ok = (lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Decode the stage inputs into legality and the lane-steered request
  always_comb begin
    access_s = MemReadM | MemWriteM;
    store_s  = MemWriteM;
    legal_s  = f3_legal(store_s, funct3M) && f3_aligned(funct3M, ALUResultM[1:0]);
    if (store_s) begin
      be_s    = store_be(funct3M, ALUResultM[1:0]);
      wdata_s = store_wdata(funct3M, WriteDataM);
    end else begin
      be_s    = 4'b1111;
      wdata_s = 32'h0000_0000;
    end
  end

  // Gated by rst_n so the stall drops the instant reset asserts
  assign StallM = rst_n & access_s & (state_r != DONE);

  // Access sequencer: issue, wait for ack or timeout, present result for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      fn3_r     <= 3'b000;
      off_r     <= 2'b00;
      ReadDataM <= 32'h0000_0000;
      ErrM      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_be    <= 4'b0000;
    end else begin
      case (state_r)
        IDLE: begin
          ErrM <= 1'b0;
          if (access_s) begin
            if (legal_s) begin
              mem_req   <= 1'b1;
              mem_we    <= store_s;
              mem_addr  <= {ALUResultM[31:2], 2'b00};
              mem_wdata <= wdata_s;
              mem_be    <= be_s;
              fn3_r     <= funct3M;
              off_r     <= ALUResultM[1:0];
              cnt_r     <= '0;
              state_r   <= REQ;
            end else begin
              ReadDataM <= 32'h0000_0000;
              ErrM      <= 1'b1;
              state_r   <= DONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          // Ack takes priority over a timeout expiring in the same cycle
          if (mem_ack) begin
            mem_req   <= 1'b0;
            ReadDataM <= mem_we ? 32'h0000_0000 : load_format(fn3_r, off_r, mem_rdata);
            ErrM      <= 1'b0;
            state_r   <= DONE;
          end else if (cnt_r == CNT_LAST) begin
            mem_req   <= 1'b0;
            ReadDataM <= 32'h0000_0000;
            ErrM      <= 1'b1;
            state_r   <= DONE;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          ErrM    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          ErrM    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pl_mem_access.sv
// Scoreboard bench for pl_mem_access: results queued at issue, compared when the stall releases.
module tb_pl_mem_access;

  logic        clk;
  logic        rst_n;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        ErrM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_rdata = 32'h0;

  pl_mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ReadDataM(ReadDataM), .StallM(StallM), .ErrM(ErrM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at negedge+1 with the DUT idle; returns at negedge+1 with the DUT idle again.
  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdata, input int ack_at,
                            input logic [31:0] e_rdata, input logic e_err,
                            input int e_stall, input int e_req,
                            input logic [31:0] e_addr, input logic [31:0] e_wdata,
                            input logic [3:0] e_be, input logic e_we);
    exp_t        e;
    exp_t        got;
    int          stall_n = 0;
    int          req_n   = 0;
    int          cyc     = 0;
    logic        done    = 1'b0;
    logic [31:0] c_addr  = 32'h0;
    logic [31:0] c_wdata = 32'h0;
    logic [3:0]  c_be    = 4'h0;
    logic        c_we    = 1'b0;
    MemReadM   = rd;
    MemWriteM  = wr;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    e.rdata = e_rdata;
    e.err   = e_err;
    sb_q.push_back(e);
    #1;
    while (!done && cyc < 40) begin
      if (!StallM) begin
        done = 1'b1;
        mem_ack = 1'b0;
        got = sb_q.pop_front();
        check({name, ".rdata"}, ReadDataM, got.rdata);
        check({name, ".err"}, {31'h0, ErrM}, {31'h0, got.err});
        last_rdata = got.rdata;
      end else begin
        if (stall_n == 0) check({name, ".hold"}, ReadDataM, last_rdata);
        stall_n++;
        if (mem_req) begin
          req_n++;
          if (req_n == 1) begin
            c_addr = mem_addr; c_wdata = mem_wdata; c_be = mem_be; c_we = mem_we;
          end
          mem_rdata = rdata;
          mem_ack   = (req_n == ack_at);
        end else begin
          mem_ack = 1'b0;
        end
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        #1;
        cyc++;
      end
    end
    check({name, ".done"}, {31'h0, done}, 32'h1);
    if (!done) got = sb_q.pop_front();
    check({name, ".stall"}, 32'(stall_n), 32'(e_stall));
    check({name, ".req"}, 32'(req_n), 32'(e_req));
    if (e_req > 0) begin
      check({name, ".addr"}, c_addr, e_addr);
      check({name, ".wdata"}, c_wdata, e_wdata);
      check({name, ".be"}, {28'h0, c_be}, {28'h0, e_be});
      check({name, ".we"}, {31'h0, c_we}, {31'h0, e_we});
    end
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    mem_ack   = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ALUResultM = 32'h0; WriteDataM = 32'h0; MemReadM = 1'b0; MemWriteM = 1'b0;
    funct3M = 3'b000; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.req", {31'h0, mem_req}, 32'h0);
    check("rst.stall", {31'h0, StallM}, 32'h0);
    check("rst.err", {31'h0, ErrM}, 32'h0);
    check("rst.rdata", ReadDataM, 32'h0);
    check("rst.addr", mem_addr, 32'h0);
    check("rst.be", {28'h0, mem_be}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    //          name    rd    wr    f3      addr          wd            rdata         ack rdata_exp    err  st req addr         wdata         be       we
    run_access("lw",   1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b0, 2, 1, 32'h0000_0100, 32'h0,        4'b1111, 1'b0);
    run_access("lb",   1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1, 32'hFFFF_FF80, 1'b0, 2, 1, 32'h0000_0100, 32'h0,        4'b1111, 1'b0);
    run_access("lbu",  1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1, 32'h0000_0080, 1'b0, 2, 1, 32'h0000_0100, 32'h0,        4'b1111, 1'b0);
    run_access("sh",   1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0,        3, 32'h0,        1'b0, 4, 3, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 1'b1);
    run_access("sb",   1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h0,        1, 32'h0,        1'b0, 2, 1, 32'h0000_0200, 32'hA5A5_A5A5, 4'b0010, 1'b1);
    run_access("sw",   1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h1122_3344, 32'h0,        1, 32'h0,        1'b0, 2, 1, 32'h0000_0300, 32'h1122_3344, 4'b1111, 1'b1);
    run_access("rdwr", 1'b1, 1'b1, 3'b010, 32'h0000_0400, 32'h0000_0055, 32'h7777_7777, 1, 32'h0,        1'b0, 2, 1, 32'h0000_0400, 32'h0000_0055, 4'b1111, 1'b1);
    run_access("lwok", 1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'h1234_5678, 1, 32'h1234_5678, 1'b0, 2, 1, 32'h0000_0104, 32'h0,        4'b1111, 1'b0);
    run_access("lwma", 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         1, 32'h0,        1'b1, 1, 0, 32'h0,        32'h0,        4'b0000, 1'b0);
    run_access("lhma", 1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h0,         1, 32'h0,        1'b1, 1, 0, 32'h0,        32'h0,        4'b0000, 1'b0);
    run_access("ld11", 1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         1, 32'h0,        1'b1, 1, 0, 32'h0,        32'h0,        4'b0000, 1'b0);
    run_access("sbu",  1'b0, 1'b1, 3'b100, 32'h0000_0400, 32'h0,        32'h0,         1, 32'h0,        1'b1, 1, 0, 32'h0,        32'h0,        4'b0000, 1'b0);
    run_access("swma", 1'b0, 1'b1, 3'b010, 32'h0000_0402, 32'h0,        32'h0,         1, 32'h0,        1'b1, 1, 0, 32'h0,        32'h0,        4'b0000, 1'b0);
    run_access("tmo",  1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hCAFE_F00D, 0, 32'h0,        1'b1, 5, 4, 32'h0000_0100, 32'h0,        4'b1111, 1'b0);
    run_access("ack4", 1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'h1234_5678, 4, 32'h1234_5678, 1'b0, 5, 4, 32'h0000_0104, 32'h0,        4'b1111, 1'b0);
    run_access("lh",   1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 1, 32'hFFFF_8001, 1'b0, 2, 1, 32'h0000_0100, 32'h0,        4'b1111, 1'b0);
    run_access("lhu",  1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_1234, 2, 32'h0000_8001, 1'b0, 3, 2, 32'h0000_0100, 32'h0,        4'b1111, 1'b0);

    // Non-memory instruction: no stall, no bus request
    #1;
    check("nomem.stall", {31'h0, StallM}, 32'h0);
    check("nomem.req", {31'h0, mem_req}, 32'h0);

    // Asynchronous reset in the middle of a request
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_0500;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("midrst.req_before", {31'h0, mem_req}, 32'h1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst.req", {31'h0, mem_req}, 32'h0);
    check("midrst.stall", {31'h0, StallM}, 32'h0);
    check("midrst.err", {31'h0, ErrM}, 32'h0);
    check("midrst.rdata", ReadDataM, 32'h0);
    check("midrst.addr", mem_addr, 32'h0);
    check("midrst.be", {28'h0, mem_be}, 32'h0);
    check("midrst.we", {31'h0, mem_we}, 32'h0);
    MemReadM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 32'h0;
    @(negedge clk);
    #1;
    check("postrst.stall", {31'h0, StallM}, 32'h0);
    run_access("postrst", 1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 1'b0, 2, 1, 32'h0000_0600, 32'h0, 4'b1111, 1'b0);

    check("sb.empty", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pl_mem_access.md
Name: pl_mem_access

Overview:
Memory-stage load/store unit between the execute/memory and memory/writeback pipeline registers. It turns the stage's address, store data and funct3 into a word-aligned request/acknowledge transaction on the data-memory bus. It handles byte-lane steering, load sign/zero extension and misalignment detection. It holds the pipeline stall high until the access completes, then presents ReadDataM for capture by the memory/writeback register.

Parameters:
TIMEOUT, 16, max cycles in REQ waiting for mem_ack before aborting with bus error (min 1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
ALUResultM  input  32  byte address of access
WriteDataM  input  32  store data (rs2), unaligned in low bits
MemReadM  input  1  load in memory stage
MemWriteM  input  1  store in memory stage
funct3M  input  3  access size/sign (RISC-V encoding)
ReadDataM  output  32  formatted load result
StallM  output  1  freeze fetch..memory stages, hold memory/writeback register
ErrM  output  1  one-cycle pulse: misaligned, illegal funct3 or timeout
mem_req  output  1  bus request, held until mem_ack or timeout
mem_we  output  1  1 = write
mem_addr  output  32  {ALUResultM[31:2],2'b00}, registered at issue
mem_wdata  output  32  lane-replicated store data, registered at issue
mem_be  output  4  byte enables, registered at issue
mem_rdata  input  32  read word, valid with mem_ack
mem_ack  input  1  single-cycle completion strobe

Behaviour:
- Reset (async, rst_n=0): state IDLE; ReadDataM=0, StallM=0, ErrM=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0; timeout counter 0.
- access = MemReadM | MemWriteM. If both are high, treat as a store.
- StallM = access & (state != DONE), combinational. It is 0 in IDLE when there is no access.
- FSM IDLE -> REQ -> DONE -> IDLE:
  - IDLE with access and legal/aligned: register addr/wdata/be/we, go to REQ. The registered request outputs are stable from the first REQ cycle.
  - IDLE with access and illegal/misaligned: no bus request; go directly to DONE with error flag set.
  - REQ: mem_req=1. On mem_ack, capture mem_rdata, go to DONE. Counter increments each REQ cycle without ack; when it reaches TIMEOUT, drop mem_req, set error flag, go to DONE.
  - DONE: StallM=0; ReadDataM from the captured word (0 on error or store); ErrM=1 if the error flag is set. Always return to IDLE.
- Minimum latency: 3 cycles per access (IDLE, REQ with immediate ack, DONE). The memory/writeback register captures in the DONE cycle. Non-memory instructions pass with 0 added cycles.
- In IDLE and REQ, ReadDataM holds its last value.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
- Store steering:
  - SB: wdata={4{WriteDataM[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{WriteDataM[15:0]}}, be=addr[1]?1100:0011.
  - SW: be=1111.
  - Loads drive be=1111, we=0.
- Load formatting: select byte addr[1:0] or half addr[1] from the captured word. LB/LH sign-extend; LBU/LHU zero-extend.
- mem_ack outside REQ is ignored. An ack arriving in the same cycle the counter reaches TIMEOUT counts as success (ack wins).
- Inputs are sampled only in IDLE. Changes during REQ/DONE are ignored, since the pipeline is frozen by StallM.
- rst_n asserted mid-REQ: mem_req drops immediately (async) and the transaction is abandoned.

Test Plan:
- LW addr 0x100, mem_ack in the first REQ cycle, mem_rdata 0xDEADBEEF -> mem_addr=0x100, be=1111, StallM high 2 cycles, DONE: ReadDataM=0xDEADBEEF, StallM=0, ErrM=0.
- LB addr 0x103 and LBU addr 0x103 with rdata 0x80FF1234 -> ReadDataM=0xFFFFFF80 and 0x00000080 respectively.
- SH addr 0x202, WriteDataM 0x0000ABCD, ack after 3 cycles -> mem_we=1, mem_addr=0x200, be=1100, wdata=0xABCDABCD, mem_req high exactly 3 cycles, StallM high 4 cycles.
- LW addr 0x101 and LH addr 0x103 -> mem_req never asserted, DONE on the 2nd cycle with ErrM=1, ReadDataM=0.
- funct3=011 load -> ErrM=1, no bus activity. TIMEOUT=4 with no ack -> mem_req high 4 cycles then low, ErrM pulse, ReadDataM=0. Ack on the 4th REQ cycle -> success, ErrM=0.
- rst_n low in the middle of REQ -> mem_req, StallM and all outputs 0 without waiting for clk. After release, a non-memory instruction gives StallM=0.
